qpu_lsu_icb_master: RTL and testbench
=====================================

Name: qpu_lsu_icb_master

Overview:
- Initiator end of the LSU ICB command channel. Converts execute-stage load/store requests into word-aligned ICB commands (address, lane-replicated write data, byte write mask).
- Tracks outstanding requests in an in-order FIFO.
- Consumes the LSU write-back response, extracts the addressed byte/half/word, sign/zero extends it, and delivers it to the register-file write port with its destination index.
- Sits between the execute unit and the LSU top (the LSU + DTCM controller + DTCM RAM).

Parameters:
- XLEN, 32, data width (32 only in this block; byte lanes = XLEN/8 = 4).
- ADDR_SIZE, 32, address width.
- OSTD_DEPTH, 2, maximum outstanding commands (power of 2, >=1).
- OSTD_PTR_W, 1, log2(OSTD_DEPTH); count width = OSTD_PTR_W+1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  execute request valid
- req_ready  out  1  request accepted
- req_load  in  1  1=load, 0=store
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- req_unsigned  in  1  zero-extend load result
- req_addr  in  ADDR_SIZE  byte address
- req_wdata  in  XLEN  store data (LSB-aligned)
- req_rd  in  5  destination register index
- lsu_icb_cmd_valid  out  1  ICB command valid
- lsu_icb_cmd_ready  in  1  ICB command ready
- lsu_icb_cmd_addr  out  ADDR_SIZE  req_addr with bits [1:0] forced to 0
- lsu_icb_cmd_read  out  1  equals req_load
- lsu_icb_cmd_wdata  out  XLEN  lane-replicated store data
- lsu_icb_cmd_wmask  out  XLEN/8  byte-lane mask
- lsu_o_valid  in  1  write-back valid
- lsu_o_ready  out  1  write-back accepted
- lsu_o_wbck_rdata  in  XLEN  full-word read data
- lsu_o_cmt_ld  in  1  load access fault
- lsu_o_cmt_st  in  1  store access fault
- lsu_o_cmt_badaddr  in  ADDR_SIZE  faulting address
- wb_valid  out  1  register write-back valid
- wb_ready  in  1  register write-back accepted
- wb_we  out  1  write enable (load without fault)
- wb_rd  out  5  destination index
- wb_data  out  XLEN  extended load data
- err_valid  out  1  fault pulse (single cycle)
- err_badaddr  out  ADDR_SIZE  fault address
- err_unexp  out  1  sticky: response received with no outstanding entry
- ostd_cnt  out  OSTD_PTR_W+1  outstanding count
- lsu_idle  out  1  ostd_cnt==0

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - FIFO pointers and ostd_cnt cleared to 0; err_valid=0, err_unexp=0, err_badaddr=0.
  - In-flight commands are discarded; their later responses are handled as unexpected.
- Issue path (combinational, zero latency):
  - lsu_icb_cmd_valid = req_valid & ~full.
  - req_ready = lsu_icb_cmd_ready & ~full.
  - Push occurs on cmd handshake.
  - full is the registered count==OSTD_DEPTH. A pop in the same cycle does NOT unblock a push.
- wmask (off = req_addr[1:0]):
  - byte: 1<<off.
  - half: 2'b11<<off, truncated to 4 bits.
  - word: 4'b1111.
  - Loads also drive the computed mask.
- wdata:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- FIFO entry: {load, size, unsigned, off, rd}.
- Response path:
  - lsu_o_ready = wb_ready when non-empty, 1 when empty.
  - wb_valid = lsu_o_valid & ~empty.
  - Pop occurs on lsu_o_valid & lsu_o_ready & ~empty.
- Data extraction: sh = rdata >> (8*off).
  - byte: sign/zero extend sh[7:0].
  - half: sign/zero extend sh[15:0].
  - word: sh.
- wb_we = entry.load & ~lsu_o_cmt_ld. Store responses produce wb_valid with wb_we=0 (commit acknowledge only).
- Faults:
  - If lsu_o_cmt_ld or lsu_o_cmt_st is set on a pop, err_valid pulses on the next cycle and err_badaddr latches lsu_o_cmt_badaddr.
- Unexpected response (lsu_o_valid while empty):
  - The response is dropped and err_unexp is set; it is cleared only by rst.
- ostd_cnt: +1 on push, -1 on pop, unchanged on simultaneous push and pop. Never exceeds OSTD_DEPTH.
- Ordering: responses are strictly in order. FIFO pointers wrap modulo OSTD_DEPTH.

Optional Feature:
- Macro QPU_LSU_MISALIGN_CHK_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - A misaligned request is accepted with req_ready=~full regardless of lsu_icb_cmd_ready. No command is issued and no push occurs.
  - err_valid pulses on the next cycle with err_badaddr=req_addr.
- Undefined:
  - No check. The request issues with a truncated mask (e.g. half at off=3 -> wmask 4'b1000).
  - A load returns the shifted upper bits only.

Test Plan:
- Store byte: addr=0x103, wdata=0xA5 -> cmd_addr=0x100, wmask=4'b1000, wdata=0xA5A5A5A5, read=0; response -> wb_valid=1, wb_we=0.
- Load half signed: addr=0x202, rdata=0x8001_1234 -> wb_data=0xFFFF_8001, wb_we=1. Same with req_unsigned=1 -> wb_data=0x0000_8001.
- Backpressure: OSTD_DEPTH=2, three back-to-back loads with lsu_o_valid=0 -> third held with req_ready=0 and ostd_cnt=2; one response accepted -> third issues the following cycle; rd order preserved.
- Fault: load response with lsu_o_cmt_ld=1, badaddr=0x300 -> wb_we=0, err_valid=1 for one cycle on the next cycle, err_badaddr=0x300.
- Reset mid-operation: 2 outstanding, rst=1 for one cycle, then lsu_o_valid=1 -> ostd_cnt=0, response dropped, err_unexp=1.
- With QPU_LSU_MISALIGN_CHK_EN: word load at 0x401 -> lsu_icb_cmd_valid stays 0, err_valid=1, err_badaddr=0x401, ostd_cnt unchanged.

Source files
------------

// File: rtl/qpu_lsu_icb_master_if.sv
// Bundle of the execute-request, ICB command, write-back response,
// register write-back and status signals of the LSU ICB master.
// The master modport is the LSU ICB master's view of the bundle.
// The slave modport is the view of the surrounding execute unit and LSU.
interface qpu_lsu_icb_master_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_SIZE  = 32,
  parameter int OSTD_PTR_W = 1
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_load;
  logic [1:0]             req_size;
  logic                   req_unsigned;
  logic [ADDR_SIZE-1:0]   req_addr;
  logic [XLEN-1:0]        req_wdata;
  logic [4:0]             req_rd;

  logic                   lsu_icb_cmd_valid;
  logic                   lsu_icb_cmd_ready;
  logic [ADDR_SIZE-1:0]   lsu_icb_cmd_addr;
  logic                   lsu_icb_cmd_read;
  logic [XLEN-1:0]        lsu_icb_cmd_wdata;
  logic [XLEN/8-1:0]      lsu_icb_cmd_wmask;

  logic                   lsu_o_valid;
  logic                   lsu_o_ready;
  logic [XLEN-1:0]        lsu_o_wbck_rdata;
  logic                   lsu_o_cmt_ld;
  logic                   lsu_o_cmt_st;
  logic [ADDR_SIZE-1:0]   lsu_o_cmt_badaddr;

  logic                   wb_valid;
  logic                   wb_ready;
  logic                   wb_we;
  logic [4:0]             wb_rd;
  logic [XLEN-1:0]        wb_data;

  logic                   err_valid;
  logic [ADDR_SIZE-1:0]   err_badaddr;
  logic                   err_unexp;
  logic [OSTD_PTR_W:0]    ostd_cnt;
  logic                   lsu_idle;

  modport master (
    input  req_valid, req_load, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output req_ready,
    output lsu_icb_cmd_valid, lsu_icb_cmd_addr, lsu_icb_cmd_read,
           lsu_icb_cmd_wdata, lsu_icb_cmd_wmask,
    input  lsu_icb_cmd_ready,
    input  lsu_o_valid, lsu_o_wbck_rdata, lsu_o_cmt_ld, lsu_o_cmt_st, lsu_o_cmt_badaddr,
    output lsu_o_ready,
    output wb_valid, wb_we, wb_rd, wb_data,
    input  wb_ready,
    output err_valid, err_badaddr, err_unexp, ostd_cnt, lsu_idle
  );

  modport slave (
    output req_valid, req_load, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  lsu_icb_cmd_valid, lsu_icb_cmd_addr, lsu_icb_cmd_read,
           lsu_icb_cmd_wdata, lsu_icb_cmd_wmask,
    output lsu_icb_cmd_ready,
    output lsu_o_valid, lsu_o_wbck_rdata, lsu_o_cmt_ld, lsu_o_cmt_st, lsu_o_cmt_badaddr,
    input  lsu_o_ready,
    input  wb_valid, wb_we, wb_rd, wb_data,
    output wb_ready,
    input  err_valid, err_badaddr, err_unexp, ostd_cnt, lsu_idle
  );
endinterface

// File: rtl/qpu_lsu_icb_master.sv
// LSU ICB command initiator: turns execute-stage load/store requests into
// word-aligned ICB commands, tracks outstanding commands in an in-order
// FIFO and returns extended load data to the register-file write port.
// Optional misalignment check: define QPU_LSU_MISALIGN_CHK_EN.
module qpu_lsu_icb_master #(
  parameter int XLEN       = 32,
  parameter int ADDR_SIZE  = 32,
  parameter int OSTD_DEPTH = 2,
  parameter int OSTD_PTR_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  qpu_lsu_icb_master_if.master  bus
);

  localparam int NB = XLEN / 8;
  localparam int PW = (OSTD_PTR_W > 0) ? OSTD_PTR_W : 1;
  localparam int CW = OSTD_PTR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OSTD_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(OSTD_DEPTH - 1);

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  full, empty;
  logic                  mis, mis_take;
  logic                  push, pop, fault;
  logic [1:0]            off;

  logic [OSTD_DEPTH-1:0] ent_load, ent_uns;
  logic [1:0]            ent_size [OSTD_DEPTH];
  logic [1:0]            ent_off  [OSTD_DEPTH];
  logic [4:0]            ent_rd   [OSTD_DEPTH];

  logic                  h_load, h_uns;
  logic [1:0]            h_size, h_off;
  logic [XLEN-1:0]       sh;
  logic [NB-1:0]         wmask;
  logic [XLEN-1:0]       wdata;
  logic [XLEN-1:0]       ext;

  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign off   = bus.req_addr[1:0];

`ifdef QPU_LSU_MISALIGN_CHK_EN
  // Half needs even address, word (and reserved size) needs word alignment.
  always_comb begin
    mis = 1'b0;
    case (bus.req_size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      default: mis = (off != 2'd0);
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  // A misaligned request is swallowed here and never reaches the ICB.
  assign mis_take              = bus.req_valid & mis & ~full;
  assign bus.lsu_icb_cmd_valid = bus.req_valid & ~full & ~mis;
  assign bus.req_ready         = ~full & (mis | bus.lsu_icb_cmd_ready);
  assign push                  = bus.lsu_icb_cmd_valid & bus.lsu_icb_cmd_ready;

  // Byte-lane mask and lane-replicated store data from size and offset.
  always_comb begin
    wmask = '0;
    wdata = bus.req_wdata;
    case (bus.req_size)
      2'd0: begin
        wmask = NB'(1) << off;
        wdata = {NB{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        wmask = NB'(3) << off;
        wdata = {(NB/2){bus.req_wdata[15:0]}};
      end
      default: begin
        wmask = '1;
        wdata = bus.req_wdata;
      end
    endcase
  end

  assign bus.lsu_icb_cmd_addr  = {bus.req_addr[ADDR_SIZE-1:2], 2'b00};
  assign bus.lsu_icb_cmd_read  = bus.req_load;
  assign bus.lsu_icb_cmd_wmask = wmask;
  assign bus.lsu_icb_cmd_wdata = wdata;

  assign h_load = ent_load[rd_ptr];
  assign h_uns  = ent_uns[rd_ptr];
  assign h_size = ent_size[rd_ptr];
  assign h_off  = ent_off[rd_ptr];

  // Pick the addressed byte/half out of the returned word and extend it.
  assign sh = bus.lsu_o_wbck_rdata >> {h_off, 3'b000};
  always_comb begin
    ext = sh;
    case (h_size)
      2'd0:    ext = {{(XLEN-8){sh[7] & ~h_uns}}, sh[7:0]};
      2'd1:    ext = {{(XLEN-16){sh[15] & ~h_uns}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  // Responses arriving with nothing outstanding are always accepted and dropped.
  assign bus.lsu_o_ready = empty | bus.wb_ready;
  assign bus.wb_valid    = bus.lsu_o_valid & ~empty;
  assign bus.wb_we       = h_load & ~bus.lsu_o_cmt_ld;
  assign bus.wb_rd       = ent_rd[rd_ptr];
  assign bus.wb_data     = ext;
  assign pop             = bus.lsu_o_valid & bus.wb_ready & ~empty;
  assign fault           = pop & (bus.lsu_o_cmt_ld | bus.lsu_o_cmt_st);

  assign bus.ostd_cnt = cnt;
  assign bus.lsu_idle = empty;

  // Pointers and occupancy count; full is registered so a same-cycle pop
  // never lets a push through.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage needs no reset: it is only read while the count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_load[wr_ptr] <= bus.req_load;
      ent_uns[wr_ptr]  <= bus.req_unsigned;
      ent_size[wr_ptr] <= bus.req_size;
      ent_off[wr_ptr]  <= off;
      ent_rd[wr_ptr]   <= bus.req_rd;
    end
  end

  // Fault / misalignment pulse and captured address, plus sticky unexpected flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err_valid   <= 1'b0;
      bus.err_badaddr <= '0;
      bus.err_unexp   <= 1'b0;
    end else begin
      bus.err_valid <= fault | mis_take;
      if (fault)
        bus.err_badaddr <= bus.lsu_o_cmt_badaddr;
      else if (mis_take)
        bus.err_badaddr <= bus.req_addr;
      if (bus.lsu_o_valid & empty)
        bus.err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qpu_lsu_icb_master.sv
// Self-checking bench for qpu_lsu_icb_master.
module tb_qpu_lsu_icb_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qpu_lsu_icb_master_if #(.XLEN(32), .ADDR_SIZE(32), .OSTD_PTR_W(1)) bus ();

  qpu_lsu_icb_master #(
    .XLEN(32), .ADDR_SIZE(32), .OSTD_DEPTH(2), .OSTD_PTR_W(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid         = 1'b0;
    bus.req_load          = 1'b0;
    bus.req_size          = 2'd0;
    bus.req_unsigned      = 1'b0;
    bus.req_addr          = '0;
    bus.req_wdata         = '0;
    bus.req_rd            = '0;
    bus.lsu_icb_cmd_ready = 1'b0;
    bus.lsu_o_valid       = 1'b0;
    bus.lsu_o_wbck_rdata  = '0;
    bus.lsu_o_cmt_ld      = 1'b0;
    bus.lsu_o_cmt_st      = 1'b0;
    bus.lsu_o_cmt_badaddr = '0;
    bus.wb_ready          = 1'b0;
  endtask

  task automatic drive_req(input logic ld, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    bus.req_valid    = 1'b1;
    bus.req_load     = ld;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
  endtask

  // Reference model: byte-level view of lanes, sizes and extension.
  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_mask(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] m = '0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(off) && i < int'(off) + nbytes_of(sz)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r = '0;
    int nb = nbytes_of(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [1:0] sz,
                                         input logic uns, input logic [1:0] off);
    int unsigned v = 0;
    int nb = nbytes_of(sz);
    for (int i = 0; i < nb; i++)
      if (int'(off) + i < 4) v = v + (32'(rdata[8*(int'(off)+i) +: 8]) << (8*i));
    if (!uns && nb < 4 && v >= (32'd1 << (8*nb-1))) v = v - (32'd1 << (8*nb));
    return v;
  endfunction

  typedef struct {
    logic        ld;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
  } vec_t;

  typedef struct {
    logic       ld;
    logic [1:0] sz;
    logic       uns;
    logic [1:0] off;
    logic [4:0] rd;
  } ent_t;

  vec_t vt [10];
  ent_t q [$];

  initial begin
    vt[0] = '{1'b0, 2'd0, 1'b0, 32'h103, 32'hA5,       32'h0,        32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0};
    vt[1] = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h0,        32'h80011234, 32'h200, 4'b1100, 32'h0,        32'hFFFF8001};
    vt[2] = '{1'b1, 2'd1, 1'b1, 32'h202, 32'h0,        32'h80011234, 32'h200, 4'b1100, 32'h0,        32'h00008001};
    vt[3] = '{1'b1, 2'd0, 1'b0, 32'h011, 32'h0,        32'h1234F678, 32'h010, 4'b0010, 32'h0,        32'hFFFFFFF6};
    vt[4] = '{1'b1, 2'd0, 1'b1, 32'h013, 32'h0,        32'h9A000000, 32'h010, 4'b1000, 32'h0,        32'h0000009A};
    vt[5] = '{1'b1, 2'd2, 1'b0, 32'h044, 32'h0,        32'hDEADBEEF, 32'h044, 4'b1111, 32'h0,        32'hDEADBEEF};
    vt[6] = '{1'b0, 2'd1, 1'b0, 32'h022, 32'h1234ABCD, 32'h0,        32'h020, 4'b1100, 32'hABCDABCD, 32'h0};
    vt[7] = '{1'b0, 2'd2, 1'b0, 32'h008, 32'hCAFEF00D, 32'h0,        32'h008, 4'b1111, 32'hCAFEF00D, 32'h0};
    vt[8] = '{1'b1, 2'd3, 1'b0, 32'h050, 32'h0,        32'h01020304, 32'h050, 4'b1111, 32'h0,        32'h01020304};
    vt[9] = '{1'b1, 2'd0, 1'b0, 32'h060, 32'h0,        32'h00000080, 32'h060, 4'b0001, 32'h0,        32'hFFFFFF80};

    idle();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_ostd_cnt", 32'(bus.ostd_cnt), 32'd0);
    chk("rst_idle", 32'(bus.lsu_idle), 32'd1);
    chk("rst_err_valid", 32'(bus.err_valid), 32'd0);
    chk("rst_err_unexp", 32'(bus.err_unexp), 32'd0);
    chk("rst_err_badaddr", bus.err_badaddr, 32'd0);
    chk("rst_cmd_valid", 32'(bus.lsu_icb_cmd_valid), 32'd0);

    // Table: one command then its response, FIFO empty at each start.
    for (int i = 0; i < 10; i++) begin
      idle();
      drive_req(vt[i].ld, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wdata, 5'(i + 1));
      bus.lsu_icb_cmd_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_cmd_valid", i), 32'(bus.lsu_icb_cmd_valid), 32'd1);
      chk($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'd1);
      chk($sformatf("v%0d_cmd_addr", i), bus.lsu_icb_cmd_addr, vt[i].e_addr);
      chk($sformatf("v%0d_cmd_read", i), 32'(bus.lsu_icb_cmd_read), 32'(vt[i].ld));
      chk($sformatf("v%0d_wmask", i), 32'(bus.lsu_icb_cmd_wmask), 32'(vt[i].e_mask));
      if (!vt[i].ld)
        chk($sformatf("v%0d_wdata", i), bus.lsu_icb_cmd_wdata, vt[i].e_wdata);
      tick();
      idle();
      bus.lsu_o_valid      = 1'b1;
      bus.lsu_o_wbck_rdata = vt[i].rdata;
      bus.wb_ready         = 1'b1;
      #1;
      chk($sformatf("v%0d_wb_valid", i), 32'(bus.wb_valid), 32'd1);
      chk($sformatf("v%0d_wb_we", i), 32'(bus.wb_we), 32'(vt[i].ld));
      chk($sformatf("v%0d_wb_rd", i), 32'(bus.wb_rd), 32'(i + 1));
      if (vt[i].ld)
        chk($sformatf("v%0d_wb_data", i), bus.wb_data, vt[i].e_data);
      tick();
      idle();
    end
    #1;
    chk("tbl_end_cnt", 32'(bus.ostd_cnt), 32'd0);

    // Backpressure: third load held while two are outstanding.
    idle();
    bus.lsu_icb_cmd_ready = 1'b1;
    drive_req(1'b1, 2'd2, 1'b0, 32'h500, 32'h0, 5'd1);
    tick();
    drive_req(1'b1, 2'd2, 1'b0, 32'h504, 32'h0, 5'd2);
    tick();
    drive_req(1'b1, 2'd2, 1'b0, 32'h508, 32'h0, 5'd3);
    #1;
    chk("bp_cnt_full", 32'(bus.ostd_cnt), 32'd2);
    chk("bp_req_ready_held", 32'(bus.req_ready), 32'd0);
    chk("bp_cmd_valid_held", 32'(bus.lsu_icb_cmd_valid), 32'd0);
    bus.lsu_o_valid = 1'b1;
    bus.wb_ready    = 1'b1;
    #1;
    chk("bp_pop_no_unblock", 32'(bus.req_ready), 32'd0);
    chk("bp_rd_first", 32'(bus.wb_rd), 32'd1);
    tick();
    bus.lsu_o_valid = 1'b0;
    #1;
    chk("bp_cnt_after_pop", 32'(bus.ostd_cnt), 32'd1);
    chk("bp_third_issues", 32'(bus.lsu_icb_cmd_valid), 32'd1);
    tick();
    idle();
    bus.lsu_o_valid = 1'b1;
    bus.wb_ready    = 1'b1;
    #1;
    chk("bp_cnt_refill", 32'(bus.ostd_cnt), 32'd2);
    chk("bp_rd_second", 32'(bus.wb_rd), 32'd2);
    tick();
    #1;
    chk("bp_rd_third", 32'(bus.wb_rd), 32'd3);
    chk("bp_wb_valid_third", 32'(bus.wb_valid), 32'd1);
    tick();
    idle();
    #1;
    chk("bp_drained", 32'(bus.lsu_idle), 32'd1);

    // Load access fault.
    bus.lsu_icb_cmd_ready = 1'b1;
    drive_req(1'b1, 2'd2, 1'b0, 32'h300, 32'h0, 5'd7);
    tick();
    idle();
    bus.lsu_o_valid       = 1'b1;
    bus.wb_ready          = 1'b1;
    bus.lsu_o_cmt_ld      = 1'b1;
    bus.lsu_o_cmt_badaddr = 32'h300;
    #1;
    chk("flt_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("flt_wb_we", 32'(bus.wb_we), 32'd0);
    chk("flt_err_not_yet", 32'(bus.err_valid), 32'd0);
    tick();
    idle();
    #1;
    chk("flt_err_valid", 32'(bus.err_valid), 32'd1);
    chk("flt_err_badaddr", bus.err_badaddr, 32'h300);
    tick();
    #1;
    chk("flt_err_pulse_end", 32'(bus.err_valid), 32'd0);

`ifdef QPU_LSU_MISALIGN_CHK_EN
    drive_req(1'b1, 2'd2, 1'b0, 32'h401, 32'h0, 5'd9);
    #1;
    chk("mis_cmd_valid", 32'(bus.lsu_icb_cmd_valid), 32'd0);
    chk("mis_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    idle();
    #1;
    chk("mis_err_valid", 32'(bus.err_valid), 32'd1);
    chk("mis_err_badaddr", bus.err_badaddr, 32'h401);
    chk("mis_cnt", 32'(bus.ostd_cnt), 32'd0);
    tick();
    #1;
    chk("mis_err_pulse_end", 32'(bus.err_valid), 32'd0);
`endif

    // Randomized traffic against the queue model (aligned accesses only).
    idle();
    tick();
    begin
      logic        exp_ev = 1'b0;
      logic        exp_unexp = 1'b0;
      logic [31:0] exp_bad = 32'h0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        logic [1:0]  sz;
        logic [1:0]  o;
        logic [31:0] a;
        logic        full, empty, push, pop, next_ev;
        ent_t        e;
        int          n;
        sz = 2'($urandom_range(0, 3));
        o  = 2'($urandom_range(0, 3));
        if (sz == 2'd1) o[0] = 1'b0;
        if (sz >= 2'd2) o = 2'd0;
        a = $urandom;
        a[1:0] = o;
        bus.req_valid         = ($urandom_range(0, 2) != 0);
        bus.req_load          = 1'($urandom_range(0, 1));
        bus.req_size          = sz;
        bus.req_unsigned      = 1'($urandom_range(0, 1));
        bus.req_addr          = a;
        bus.req_wdata         = $urandom;
        bus.req_rd            = 5'($urandom_range(0, 31));
        bus.lsu_icb_cmd_ready = ($urandom_range(0, 3) != 0);
        bus.lsu_o_valid       = ($urandom_range(0, 1) != 0);
        bus.lsu_o_wbck_rdata  = $urandom;
        bus.lsu_o_cmt_ld      = ($urandom_range(0, 7) == 0);
        bus.lsu_o_cmt_st      = ($urandom_range(0, 7) == 0);
        bus.lsu_o_cmt_badaddr = $urandom;
        bus.wb_ready          = ($urandom_range(0, 3) != 0);
        #2;
        n     = q.size();
        full  = (n == 2);
        empty = (n == 0);
        chk("rnd_cmd_valid", 32'(bus.lsu_icb_cmd_valid), 32'(bus.req_valid && !full));
        chk("rnd_req_ready", 32'(bus.req_ready), 32'(bus.lsu_icb_cmd_ready && !full));
        if (bus.req_valid && !full) begin
          chk("rnd_cmd_addr", bus.lsu_icb_cmd_addr, a - 32'(o));
          chk("rnd_cmd_read", 32'(bus.lsu_icb_cmd_read), 32'(bus.req_load));
          chk("rnd_wmask", 32'(bus.lsu_icb_cmd_wmask), 32'(m_mask(sz, o)));
          if (!bus.req_load)
            chk("rnd_wdata", bus.lsu_icb_cmd_wdata, m_wdata(sz, bus.req_wdata));
        end
        chk("rnd_o_ready", 32'(bus.lsu_o_ready), 32'(empty || bus.wb_ready));
        chk("rnd_wb_valid", 32'(bus.wb_valid), 32'(bus.lsu_o_valid && !empty));
        if (bus.lsu_o_valid && !empty) begin
          chk("rnd_wb_rd", 32'(bus.wb_rd), 32'(q[0].rd));
          chk("rnd_wb_we", 32'(bus.wb_we), 32'(q[0].ld && !bus.lsu_o_cmt_ld));
          if (q[0].ld && !bus.lsu_o_cmt_ld)
            chk("rnd_wb_data", bus.wb_data,
                m_load(bus.lsu_o_wbck_rdata, q[0].sz, q[0].uns, q[0].off));
        end
        chk("rnd_ostd_cnt", 32'(bus.ostd_cnt), 32'(n));
        chk("rnd_idle", 32'(bus.lsu_idle), 32'(empty));
        chk("rnd_err_valid", 32'(bus.err_valid), 32'(exp_ev));
        if (exp_ev) chk("rnd_err_badaddr", bus.err_badaddr, exp_bad);
        chk("rnd_err_unexp", 32'(bus.err_unexp), 32'(exp_unexp));
        push    = bus.req_valid && !full && bus.lsu_icb_cmd_ready;
        pop     = bus.lsu_o_valid && !empty && bus.wb_ready;
        next_ev = pop && (bus.lsu_o_cmt_ld || bus.lsu_o_cmt_st);
        if (next_ev) exp_bad = bus.lsu_o_cmt_badaddr;
        if (bus.lsu_o_valid && empty) exp_unexp = 1'b1;
        e = '{bus.req_load, sz, bus.req_unsigned, o, bus.req_rd};
        tick();
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        exp_ev = next_ev;
      end
    end

    // Reset with commands in flight; the late response is unexpected.
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.lsu_icb_cmd_ready = 1'b1;
    drive_req(1'b1, 2'd2, 1'b0, 32'h600, 32'h0, 5'd4);
    tick();
    drive_req(1'b1, 2'd2, 1'b0, 32'h604, 32'h0, 5'd5);
    tick();
    idle();
    #1;
    chk("rm_cnt_two", 32'(bus.ostd_cnt), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rm_cnt_cleared", 32'(bus.ostd_cnt), 32'd0);
    chk("rm_unexp_clear", 32'(bus.err_unexp), 32'd0);
    bus.lsu_o_valid = 1'b1;
    #1;
    chk("rm_o_ready", 32'(bus.lsu_o_ready), 32'd1);
    chk("rm_wb_dropped", 32'(bus.wb_valid), 32'd0);
    tick();
    idle();
    #1;
    chk("rm_err_unexp", 32'(bus.err_unexp), 32'd1);
    chk("rm_cnt_still0", 32'(bus.ostd_cnt), 32'd0);
    tick();
    #1;
    chk("rm_unexp_sticky", 32'(bus.err_unexp), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
